// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port SRAM arbiter.
// Holds the FSM state encoding, the owner encoding and the default access length.
// Ports: none (package).
package pipe_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int WAIT_CYCLES_DEF = 4;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the IF (fetch) and MEM (load/store) pipeline stages onto one
// asynchronous SRAM; MEM has priority, each access takes WAIT_CYCLES clocks.
// Ports: clk/rst; i_if_* fetch request; i_mem_* load/store request;
//        o_*_ready/o_*_rdata completions; o_*_stall pipeline freezes;
//        o_sram_*/i_sram_rdata SRAM pins (active-low enables).
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [31:0]       i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  output logic              o_if_ready,
  output logic              o_mem_ready,
  output logic [31:0]       o_if_rdata,
  output logic [31:0]       o_mem_rdata,
  output logic              o_if_stall,
  output logic              o_mem_stall,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  input  logic [31:0]       i_sram_rdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  // Last count with WE low; WE rises one cycle before the access ends so
  // address and data stay stable across the WE rising edge.
  localparam logic [CNT_W-1:0] CNT_WE_END = CNT_W'(WAIT_CYCLES - 2);

  state_t             r_state;
  owner_t             r_owner;
  logic               r_is_wr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [31:0]        r_sram_wdata;
  logic               r_we_n;
  logic               r_oe_n;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_mem_rdata;

  logic               w_mem_req;
  logic               w_resp;
  logic               w_unused_addr;

  assign w_mem_req = i_mem_rd | i_mem_wr;
  assign w_resp    = (r_state == ST_RESP);

  // Only the word-address bits reach the SRAM; the rest are intentionally dropped.
  assign w_unused_addr = ^{i_if_addr, i_mem_addr};

  // Ready is gated by the owner's live request so a flushed fetch (or a
  // dropped MEM request) never sees a completion.
  assign o_if_ready  = w_resp && (r_owner == OWN_IF)  && i_if_req;
  assign o_mem_ready = w_resp && (r_owner == OWN_MEM) && w_mem_req;

  assign o_if_stall  = i_if_req  & ~o_if_ready;
  assign o_mem_stall = w_mem_req & ~o_mem_ready;

  assign o_if_rdata   = r_if_rdata;
  assign o_mem_rdata  = r_mem_rdata;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_wdata = r_sram_wdata;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_oe_n  = r_oe_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_is_wr      <= 1'b0;
      r_cnt        <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // MEM is the older instruction, so it wins any tie.
          if (w_mem_req) begin
            r_owner      <= OWN_MEM;
            r_is_wr      <= i_mem_wr;
            r_cnt        <= '0;
            r_sram_addr  <= i_mem_addr[ADDR_W+1:2];
            r_sram_wdata <= i_mem_wdata;
            r_we_n       <= ~i_mem_wr;
            r_oe_n       <= i_mem_wr;
            r_state      <= ST_ACCESS;
          end else if (i_if_req) begin
            r_owner     <= OWN_IF;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_sram_addr <= i_if_addr[ADDR_W+1:2];
            r_oe_n      <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_wr && (r_cnt == CNT_WE_END)) begin
            r_we_n <= 1'b1;
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= ST_RESP;
            if (!r_is_wr) begin
              if (r_owner == OWN_MEM) begin
                r_mem_rdata <= i_sram_rdata;
              end else begin
                r_if_rdata <= i_sram_rdata;
              end
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios per task, with
// expected read data queued at stimulus time and popped when a ready appears.
// Ports: none (top-level bench).
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_ready;
  logic        mem_ready;
  logic [31:0] if_rdata;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  always #5 clk = ~clk;

  pipe_mem_arbiter #(.WAIT_CYCLES(4), .ADDR_W(18)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .i_mem_rd     (mem_rd),
    .i_mem_wr     (mem_wr),
    .i_mem_addr   (mem_addr),
    .i_mem_wdata  (mem_wdata),
    .o_if_ready   (if_ready),
    .o_mem_ready  (mem_ready),
    .o_if_rdata   (if_rdata),
    .o_mem_rdata  (mem_rdata),
    .o_if_stall   (if_stall),
    .o_mem_stall  (mem_stall),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata),
    .o_sram_we_n  (sram_we_n),
    .o_sram_oe_n  (sram_oe_n)
  );

  // Scoreboard consumer: every ready pulse must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_ready === 1'b1) begin
      checks++;
      if (if_q.size() == 0) begin
        errors++;
        $display("FAIL sb_if: unexpected if_ready, rdata=%h", if_rdata);
      end else begin
        e = if_q.pop_front();
        if (e.chk && (if_rdata !== e.dat)) begin
          errors++;
          $display("FAIL sb_if_rdata: got=%h exp=%h", if_rdata, e.dat);
        end
      end
    end
    if (mem_ready === 1'b1) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL sb_mem: unexpected mem_ready, rdata=%h", mem_rdata);
      end else begin
        e = mem_q.pop_front();
        if (e.chk && (mem_rdata !== e.dat)) begin
          errors++;
          $display("FAIL sb_mem_rdata: got=%h exp=%h", mem_rdata, e.dat);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    sram_rdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sram_we_n, sram_oe_n} !== 2'b11) begin
      errors++; $display("FAIL reset_enables: got=%b exp=11", {sram_we_n, sram_oe_n});
    end
    checks++;
    if ({if_ready, mem_ready, if_stall, mem_stall} !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_stall: got=%b exp=0000", {if_ready, mem_ready, if_stall, mem_stall});
    end
    checks++;
    if (sram_addr !== 18'h0 || sram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_sram_bus: addr=%h wdata=%h exp=0", sram_addr, sram_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: if=%h mem=%h exp=0", if_rdata, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch();
    if_q.push_back('{1'b1, 32'hE3A0_0001});
    for (int c = 0; c < 8; c++) begin
      if_req = (c <= 5);
      if_addr = 32'h0000_0010;
      sram_rdata = 32'hE3A0_0001;
      @(negedge clk);
      checks++;
      if (if_stall !== (c <= 4)) begin
        errors++; $display("FAIL fetch_stall c=%0d got=%b", c, if_stall);
      end
      checks++;
      if (sram_oe_n !== !(c >= 1 && c <= 4)) begin
        errors++; $display("FAIL fetch_oe_n c=%0d got=%b", c, sram_oe_n);
      end
      checks++;
      if (sram_we_n !== 1'b1) begin
        errors++; $display("FAIL fetch_we_n c=%0d got=%b exp=1", c, sram_we_n);
      end
      checks++;
      if (if_ready !== (c == 5)) begin
        errors++; $display("FAIL fetch_ready c=%0d got=%b", c, if_ready);
      end
      if (c >= 1) begin
        checks++;
        if (sram_addr !== 18'h4) begin
          errors++; $display("FAIL fetch_addr c=%0d got=%h exp=4", c, sram_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    mem_q.push_back('{1'b1, 32'h1111_2222});
    if_q.push_back('{1'b1, 32'h3333_4444});
    for (int c = 0; c < 13; c++) begin
      if_req = (c <= 11);
      if_addr = 32'h0000_0020;
      mem_rd = (c <= 5);
      mem_addr = 32'h0000_0200;
      sram_rdata = (c < 6) ? 32'h1111_2222 : 32'h3333_4444;
      @(negedge clk);
      checks++;
      if (mem_ready !== (c == 5)) begin
        errors++; $display("FAIL cont_mem_ready c=%0d got=%b", c, mem_ready);
      end
      checks++;
      if (if_ready !== (c == 11)) begin
        errors++; $display("FAIL cont_if_ready c=%0d got=%b", c, if_ready);
      end
      checks++;
      if (if_stall !== (c <= 10) || mem_stall !== (c <= 4)) begin
        errors++; $display("FAIL cont_stall c=%0d if=%b mem=%b", c, if_stall, mem_stall);
      end
      checks++;
      if (sram_oe_n !== !((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
        errors++; $display("FAIL cont_oe_n c=%0d got=%b", c, sram_oe_n);
      end
      if (c >= 1) begin
        checks++;
        if (sram_addr !== ((c <= 6) ? 18'h80 : 18'h8)) begin
          errors++; $display("FAIL cont_addr c=%0d got=%h", c, sram_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_store();
    mem_q.push_back('{1'b0, 32'h0});
    for (int c = 0; c < 8; c++) begin
      mem_wr = (c <= 5);
      mem_addr = 32'h0000_0400;
      mem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (sram_we_n !== !(c >= 1 && c <= 3)) begin
        errors++; $display("FAIL store_we_n c=%0d got=%b", c, sram_we_n);
      end
      checks++;
      if (sram_oe_n !== 1'b1) begin
        errors++; $display("FAIL store_oe_n c=%0d got=%b exp=1", c, sram_oe_n);
      end
      checks++;
      if (mem_ready !== (c == 5) || mem_stall !== (c <= 4)) begin
        errors++; $display("FAIL store_ready_stall c=%0d ready=%b stall=%b", c, mem_ready, mem_stall);
      end
      if (c >= 1) begin
        checks++;
        if (sram_addr !== 18'h100 || sram_wdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL store_bus c=%0d addr=%h wdata=%h exp=100/deadbeef", c, sram_addr, sram_wdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    // Follow-up load raised in cycle 6 only completes on time if the FSM is back in IDLE.
    mem_q.push_back('{1'b1, 32'h5555_1234});
    for (int c = 0; c < 14; c++) begin
      if_req = (c <= 2);
      if_addr = 32'h0000_0040;
      mem_rd = (c >= 6 && c <= 11);
      mem_addr = 32'h0000_0080;
      sram_rdata = (c < 6) ? 32'hAAAA_0000 : 32'h5555_1234;
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0) begin
        errors++; $display("FAIL flush_if_ready c=%0d got=%b exp=0", c, if_ready);
      end
      checks++;
      if (sram_oe_n !== !((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
        errors++; $display("FAIL flush_oe_n c=%0d got=%b", c, sram_oe_n);
      end
      checks++;
      if (mem_ready !== (c == 11) || if_stall !== (c <= 2)) begin
        errors++; $display("FAIL flush_ready_stall c=%0d mem_ready=%b if_stall=%b", c, mem_ready, if_stall);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    mem_q.push_back('{1'b1, 32'h0BAD_F00D});
    for (int c = 0; c < 10; c++) begin
      mem_rd = (c <= 7);
      mem_addr = 32'h0000_0300;
      sram_rdata = 32'h0BAD_F00D;
      if (c == 2) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({sram_we_n, sram_oe_n, if_ready, mem_ready} !== 4'b1100) begin
          errors++; $display("FAIL rstmid_outputs: got=%b exp=1100", {sram_we_n, sram_oe_n, if_ready, mem_ready});
        end
        checks++;
        if (sram_addr !== 18'h0) begin
          errors++; $display("FAIL rstmid_addr: got=%h exp=0", sram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
        checks++;
        if (sram_oe_n !== !(c == 1 || (c >= 3 && c <= 6))) begin
          errors++; $display("FAIL rstmid_oe_n c=%0d got=%b", c, sram_oe_n);
        end
        checks++;
        if (mem_ready !== (c == 7)) begin
          errors++; $display("FAIL rstmid_ready c=%0d got=%b", c, mem_ready);
        end
        if (c >= 3) begin
          checks++;
          if (sram_addr !== 18'hC0) begin
            errors++; $display("FAIL rstmid_addr c=%0d got=%h exp=c0", c, sram_addr);
          end
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    if_q.push_back('{1'b1, 32'hCAFE_0001});
    if_q.push_back('{1'b1, 32'hCAFE_0002});
    for (int c = 0; c < 13; c++) begin
      if_req = (c <= 11);
      if_addr = (c < 6) ? 32'h0000_0100 : 32'h0000_0104;
      sram_rdata = (c < 6) ? 32'hCAFE_0001 : 32'hCAFE_0002;
      @(negedge clk);
      checks++;
      if (if_ready !== (c == 5 || c == 11)) begin
        errors++; $display("FAIL b2b_ready c=%0d got=%b", c, if_ready);
      end
      checks++;
      if (if_stall !== (c <= 11 && c != 5 && c != 11)) begin
        errors++; $display("FAIL b2b_stall c=%0d got=%b", c, if_stall);
      end
      if ((c >= 1 && c <= 5) || c >= 7) begin
        checks++;
        if (sram_addr !== ((c <= 5) ? 18'h40 : 18'h41)) begin
          errors++; $display("FAIL b2b_addr c=%0d got=%h", c, sram_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    next_cycle();
    test_contention();
    next_cycle();
    test_store();
    next_cycle();
    test_flush();
    next_cycle();
    test_reset_mid();
    next_cycle();
    test_back_to_back();
    repeat (2) next_cycle();
    checks++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: if_left=%0d mem_left=%0d exp=0", if_q.size(), mem_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, SRAM access length in clocks (legal range 2..15).
REQ-002 Parameter ADDR_W, default 18, SRAM word-address width.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req  in  1  fetch request; held by the IF stage until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 mem_rd, mem_wr  in  1 each  MEM-stage load/store request; mutually exclusive; held until mem_ready.
REQ-008 mem_addr, mem_wdata  in  32 each  load/store byte address and store data.
REQ-009 if_ready, mem_ready  out  1 each  one-cycle completion pulses.
REQ-010 if_rdata, mem_rdata  out  32 each  read data, valid while the matching ready is high.
REQ-011 if_stall  out  1  equals if_req AND NOT if_ready; drives the IF-stage freeze.
REQ-012 mem_stall  out  1  equals (mem_rd OR mem_wr) AND NOT mem_ready; freezes the whole pipeline.
REQ-013 sram_addr  out  ADDR_W  word address, byte address bits [ADDR_W+1:2].
REQ-014 sram_wdata  out  32  write data; sram_rdata  in  32  read data.
REQ-015 sram_we_n, sram_oe_n  out  1 each  active-low write and output enables.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP.
REQ-017 IDLE: if mem_rd or mem_wr is high, grant MEM; else if if_req is high, grant IF; else stay in IDLE.
REQ-018 MEM wins every simultaneous request, because it is the older instruction; IF waits in IDLE with if_stall high.
REQ-019 On a grant, register the owner, operation, word address and write data, clear the counter, and enter ACCESS.
REQ-020 ACCESS lasts exactly WAIT_CYCLES cycles, counted 0..WAIT_CYCLES-1; sram_addr and sram_wdata hold the registered values throughout.
REQ-021 Read: sram_oe_n low for all ACCESS cycles; sram_rdata is registered at the edge that leaves the last ACCESS cycle.
REQ-022 Write: sram_we_n low for ACCESS counts 0..WAIT_CYCLES-2 and high on the last count, so data holds past the WE rising edge; sram_oe_n stays high.
REQ-023 RESP lasts one cycle: the owner's ready is high and its rdata is valid (rdata is don't-care for writes); the next state is IDLE.
REQ-024 Latency: a request seen in IDLE at cycle 0 gets ready in cycle WAIT_CYCLES+1; back-to-back accesses are spaced WAIT_CYCLES+2 cycles apart.
REQ-025 A started access always runs to completion; requester inputs are ignored after the grant.
REQ-026 If the owner's request is low in RESP (flush or branch dropped the fetch), suppress ready; the data is discarded.
REQ-027 A request that goes low while waiting in IDLE is never granted; no partial SRAM cycle is issued.
REQ-028 Outside ACCESS: sram_we_n=1, sram_oe_n=1, sram_addr and sram_wdata hold their last values.
REQ-029 Ready outputs are registered-state decodes; the stall outputs are combinational.

Reset
REQ-030 rst forces IDLE, counter 0, owner IF, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
REQ-031 rst asserted mid-ACCESS aborts the access immediately; no ready is produced for it.
REQ-032 After rst deasserts, the first grant can occur on the first clock edge.

Structure
REQ-033 The shared package holds the FSM state encoding (2-bit: IDLE=0, ACCESS=1, RESP=2), the owner encoding (IF=0, MEM=1) and the WAIT_CYCLES default.
REQ-034 The block is a single module with no sub-modules; the wait counter is 4 bits wide.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x0000_0010, WAIT_CYCLES=4, sram_rdata=0xE3A0_0001 -> sram_addr=4, oe_n low for cycles 1-4, if_ready=1 with if_rdata=0xE3A0_0001 in cycle 5, if_stall=1 in cycles 0-4.
REQ-036 Contention: if_req and mem_rd both raised in cycle 0 -> MEM served first (mem_ready in cycle 5), IF granted in cycle 6, if_ready in cycle 11.
REQ-037 Store: mem_wr=1, mem_addr=0x0000_0400, mem_wdata=0xDEAD_BEEF -> sram_addr=0x100, we_n low in cycles 1-3 and high in cycle 4, mem_ready in cycle 5, oe_n always high.
REQ-038 Flush mid-fetch: if_req dropped in cycle 3 of an IF access -> ACCESS still completes, no if_ready pulse, FSM returns to IDLE in cycle 6.
REQ-039 Reset mid-access: rst pulsed in cycle 2 of a read -> we_n=1, oe_n=1 and both ready outputs 0 at once; a held request is regranted after release.
